// File: rtl/addr_route_slice.sv
// AXI address-channel decode stage: region decode of an AR/AW beat, forwarded through a
// 2-entry skid buffer with destination index, decode-error flag and a saturating miss log.
module addr_route_slice #(
  parameter int unsigned SLAVES = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned LEN_W  = 4,
  parameter logic [ADDR_W-1:0] BASE  [0:SLAVES-1] = '{32'h0000_0000, 32'h1000_0000},
  parameter logic [ADDR_W-1:0] LIMIT [0:SLAVES-1] = '{32'h0fff_ffff, 32'h1fff_ffff},
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned DW    = $clog2(SLAVES + 1)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [ID_W-1:0]   s_id,
  input  logic [LEN_W-1:0]  s_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ID_W-1:0]   m_id,
  output logic [LEN_W-1:0]  m_len,
  output logic [DW-1:0]     m_dest,
  output logic              m_decerr,
  input  logic              clr_miss,
  output logic [CNT_W-1:0]  miss_count,
  output logic              miss_valid,
  output logic [ADDR_W-1:0] miss_addr
);

  localparam logic [DW-1:0]    DestErr = DW'(SLAVES);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [DW-1:0] dec_dest;
  logic          dec_err;

  // Scan from the top down so the lowest matching region is the last one written.
  always_comb begin
    dec_dest = DestErr;
    for (int i = int'(SLAVES) - 1; i >= 0; i--) begin
      if ((s_addr >= BASE[i]) && (s_addr <= LIMIT[i])) begin
        dec_dest = DW'(i);
      end
    end
    dec_err = (dec_dest == DestErr);
  end

  logic              main_valid_q, skid_valid_q;
  logic [ADDR_W-1:0] main_addr_q,  skid_addr_q;
  logic [ID_W-1:0]   main_id_q,    skid_id_q;
  logic [LEN_W-1:0]  main_len_q,   skid_len_q;
  logic [DW-1:0]     main_dest_q,  skid_dest_q;
  logic              main_err_q,   skid_err_q;

  logic acc, pop;

  assign s_ready = ~skid_valid_q;
  assign acc     = s_valid & s_ready;
  assign pop     = main_valid_q & m_ready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      main_valid_q <= 1'b0;
      main_addr_q  <= '0;
      main_id_q    <= '0;
      main_len_q   <= '0;
      main_dest_q  <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_id_q    <= '0;
      skid_len_q   <= '0;
      skid_dest_q  <= '0;
      skid_err_q   <= 1'b0;
    end else if (!main_valid_q || pop) begin
      // Main register is free this cycle: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        main_valid_q <= 1'b1;
        main_addr_q  <= skid_addr_q;
        main_id_q    <= skid_id_q;
        main_len_q   <= skid_len_q;
        main_dest_q  <= skid_dest_q;
        main_err_q   <= skid_err_q;
        skid_valid_q <= 1'b0;
      end else if (acc) begin
        main_valid_q <= 1'b1;
        main_addr_q  <= s_addr;
        main_id_q    <= s_id;
        main_len_q   <= s_len;
        main_dest_q  <= dec_dest;
        main_err_q   <= dec_err;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (acc) begin
      skid_valid_q <= 1'b1;
      skid_addr_q  <= s_addr;
      skid_id_q    <= s_id;
      skid_len_q   <= s_len;
      skid_dest_q  <= dec_dest;
      skid_err_q   <= dec_err;
    end
  end

  assign m_valid  = main_valid_q;
  assign m_addr   = main_addr_q;
  assign m_id     = main_id_q;
  assign m_len    = main_len_q;
  assign m_dest   = main_dest_q;
  assign m_decerr = main_err_q;

  logic [CNT_W-1:0]  miss_count_q, miss_count_d;
  logic              miss_valid_q, miss_valid_d;
  logic [ADDR_W-1:0] miss_addr_q,  miss_addr_d;
  logic              miss_acc;

  assign miss_acc = acc & dec_err;

  // A miss accepted alongside a clear wins: the log restarts from that miss.
  always_comb begin
    miss_count_d = miss_count_q;
    miss_valid_d = miss_valid_q;
    miss_addr_d  = miss_addr_q;
    if (clr_miss) begin
      miss_count_d = '0;
      miss_valid_d = 1'b0;
    end
    if (miss_acc) begin
      if (clr_miss) begin
        miss_count_d = CNT_W'(1);
      end else if (miss_count_q != CntMax) begin
        miss_count_d = miss_count_q + CNT_W'(1);
      end
      if (!miss_valid_q || clr_miss) begin
        miss_valid_d = 1'b1;
        miss_addr_d  = s_addr;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      miss_count_q <= '0;
      miss_valid_q <= 1'b0;
      miss_addr_q  <= '0;
    end else begin
      miss_count_q <= miss_count_d;
      miss_valid_q <= miss_valid_d;
      miss_addr_q  <= miss_addr_d;
    end
  end

  assign miss_count = miss_count_q;
  assign miss_valid = miss_valid_q;
  assign miss_addr  = miss_addr_q;

endmodule

// File: tb/tb_addr_route_slice.sv
// Bench for addr_route_slice: two instances (default map, and a 3-region overlapping map with a
// 2-bit miss counter) share stimulus and are checked against a queue-based reference model.
module tb_addr_route_slice;

  localparam logic [31:0] BASE_B  [0:2] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_1000};
  localparam logic [31:0] LIMIT_B [0:2] = '{32'h0fff_ffff, 32'h1fff_ffff, 32'h0000_1fff};

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        s_valid, m_ready, clr_miss;
  logic [31:0] s_addr;
  logic [7:0]  s_id;
  logic [3:0]  s_len;

  logic        a_s_ready, a_m_valid, a_m_decerr, a_miss_valid;
  logic [31:0] a_m_addr, a_miss_addr;
  logic [7:0]  a_m_id;
  logic [3:0]  a_m_len;
  logic [1:0]  a_m_dest;
  logic [15:0] a_miss_count;

  logic        b_s_ready, b_m_valid, b_m_decerr, b_miss_valid;
  logic [31:0] b_m_addr, b_miss_addr;
  logic [7:0]  b_m_id;
  logic [3:0]  b_m_len;
  logic [1:0]  b_m_dest;
  logic [1:0]  b_miss_count;

  always #5 ACLK = ~ACLK;

  addr_route_slice u_dut_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_addr(s_addr), .s_id(s_id), .s_len(s_len),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_addr(a_m_addr), .m_id(a_m_id), .m_len(a_m_len),
    .m_dest(a_m_dest), .m_decerr(a_m_decerr),
    .clr_miss(clr_miss), .miss_count(a_miss_count), .miss_valid(a_miss_valid),
    .miss_addr(a_miss_addr)
  );

  addr_route_slice #(
    .SLAVES(3), .CNT_W(2), .BASE(BASE_B), .LIMIT(LIMIT_B)
  ) u_dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_addr(s_addr), .s_id(s_id), .s_len(s_len),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_addr(b_m_addr), .m_id(b_m_id), .m_len(b_m_len),
    .m_dest(b_m_dest), .m_decerr(b_m_decerr),
    .clr_miss(clr_miss), .miss_count(b_miss_count), .miss_valid(b_miss_valid),
    .miss_addr(b_miss_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  id;
    logic [3:0]  len;
    int          dest_a;
    int          dest_b;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int          dest_a;
    int          dest_b;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  beat_t       q[$];
  int          cnt_a, cnt_b;
  bit          mv_a, mv_b;
  logic [31:0] ma_a, ma_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_dest(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      if (a >= BASE_B[i] && a <= LIMIT_B[i]) return i;
    end
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    cnt_a = 0; cnt_b = 0; mv_a = 0; mv_b = 0; ma_a = '0; ma_b = '0;
  endtask

  task automatic model_update();
    bit    acc, pop;
    beat_t b;
    acc = s_valid && (q.size() < 2);
    pop = (q.size() != 0) && m_ready;
    if (clr_miss) begin
      cnt_a = 0; cnt_b = 0; mv_a = 0; mv_b = 0;
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      b.addr = s_addr; b.id = s_id; b.len = s_len;
      b.dest_a = ref_dest(s_addr, 2);
      b.dest_b = ref_dest(s_addr, 3);
      q.push_back(b);
      if (b.dest_a == 2) begin
        if (cnt_a < 65535) cnt_a++;
        if (!mv_a) begin mv_a = 1; ma_a = s_addr; end
      end
      if (b.dest_b == 3) begin
        if (cnt_b < 3) cnt_b++;
        if (!mv_b) begin mv_b = 1; ma_b = s_addr; end
      end
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() != 0);
    chk("a_s_ready", a_s_ready, q.size() < 2);
    chk("b_s_ready", b_s_ready, q.size() < 2);
    chk("a_m_valid", a_m_valid, ev);
    chk("b_m_valid", b_m_valid, ev);
    if (ev) begin
      chk("a_m_addr", a_m_addr, q[0].addr);
      chk("a_m_id", a_m_id, q[0].id);
      chk("a_m_len", a_m_len, q[0].len);
      chk("a_m_dest", a_m_dest, q[0].dest_a);
      chk("a_m_decerr", a_m_decerr, q[0].dest_a == 2);
      chk("b_m_addr", b_m_addr, q[0].addr);
      chk("b_m_dest", b_m_dest, q[0].dest_b);
      chk("b_m_decerr", b_m_decerr, q[0].dest_b == 3);
    end
    chk("a_miss_count", a_miss_count, cnt_a);
    chk("a_miss_valid", a_miss_valid, mv_a);
    chk("a_miss_addr", a_miss_addr, ma_a);
    chk("b_miss_count", b_miss_count, cnt_b);
    chk("b_miss_valid", b_miss_valid, mv_b);
    chk("b_miss_addr", b_miss_addr, ma_b);
  endtask

  task automatic cycle();
    @(posedge ACLK);
    if (ARESET) model_reset();
    else model_update();
    @(negedge ACLK);
    check_outputs();
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h0000_0010, 0, 0};
    tbl[1] = '{32'h1000_0000, 1, 1};
    tbl[2] = '{32'h1fff_ffff, 1, 1};
    tbl[3] = '{32'h0fff_ffff, 0, 0};
    tbl[4] = '{32'h2000_0000, 2, 3};
    tbl[5] = '{32'h3000_0004, 2, 3};
    tbl[6] = '{32'h0000_1800, 0, 0};

    // Reset held with a beat offered
    ARESET = 1; s_valid = 1; m_ready = 1; clr_miss = 0;
    s_addr = 32'h0000_0040; s_id = 8'h01; s_len = 4'h3;
    model_reset();
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_m_addr", a_m_addr, 0);
    chk("rst_m_id", a_m_id, 0);
    chk("rst_m_len", a_m_len, 0);
    chk("rst_m_dest", a_m_dest, 0);
    chk("rst_m_decerr", a_m_decerr, 0);
    ARESET = 0;
    cycle();
    chk("first_accept_valid", a_m_valid, 1);
    chk("first_accept_addr", a_m_addr, 32'h0000_0040);

    // Back-to-back streaming from the vector table
    for (int k = 0; k < 7; k++) begin
      s_addr = tbl[k].addr; s_id = 8'(k + 8'h10); s_len = 4'(k);
      cycle();
      chk("tbl_dest_a", a_m_dest, tbl[k].dest_a);
      chk("tbl_dest_b", b_m_dest, tbl[k].dest_b);
      chk("tbl_decerr_a", a_m_decerr, tbl[k].dest_a == 2);
      chk("tbl_id", a_m_id, k + 8'h10);
    end
    s_valid = 0;
    cycle();
    chk("unmapped_count_a", a_miss_count, 2);
    chk("unmapped_count_b", b_miss_count, 2);
    chk("unmapped_addr_a", a_miss_addr, 32'h2000_0000);
    chk("unmapped_valid_a", a_miss_valid, 1);

    // Backpressure: two beats absorbed, third waits for skid to drain
    m_ready = 0; s_valid = 1;
    s_addr = 32'h0000_0100; s_id = 8'h21;
    cycle();
    chk("bp_ready_after_1", a_s_ready, 1);
    s_addr = 32'h1000_0200; s_id = 8'h22;
    cycle();
    chk("bp_ready_after_2", a_s_ready, 0);
    chk("bp_hold_addr", a_m_addr, 32'h0000_0100);
    s_addr = 32'h2000_0300; s_id = 8'h23;
    cycle();
    cycle();
    chk("bp_still_full", a_s_ready, 0);
    chk("bp_hold_id", a_m_id, 8'h21);
    m_ready = 1;
    cycle();
    chk("bp_drain_addr", a_m_addr, 32'h1000_0200);
    chk("bp_ready_back", a_s_ready, 1);
    cycle();
    chk("bp_third_addr", a_m_addr, 32'h2000_0300);
    chk("bp_third_dest", a_m_dest, 2);
    s_valid = 0;
    cycle();
    chk("bp_empty", a_m_valid, 0);

    // Counter saturation on the 2-bit instance
    clr_miss = 1;
    cycle();
    clr_miss = 0;
    chk("clr_count", a_miss_count, 0);
    chk("clr_valid", b_miss_valid, 0);
    s_valid = 1;
    for (int k = 0; k < 5; k++) begin
      s_addr = 32'h5000_0000 + 32'(k * 4);
      cycle();
    end
    s_valid = 0;
    cycle();
    chk("sat_count_b", b_miss_count, 3);
    chk("sat_count_a", a_miss_count, 5);
    chk("sat_first_addr_b", b_miss_addr, 32'h5000_0000);

    // Clear and miss accept in the same cycle
    s_valid = 1; s_addr = 32'h4000_0000; clr_miss = 1;
    cycle();
    s_valid = 0; clr_miss = 0;
    chk("clr_miss_count_a", a_miss_count, 1);
    chk("clr_miss_count_b", b_miss_count, 1);
    chk("clr_miss_addr", a_miss_addr, 32'h4000_0000);
    chk("clr_miss_valid", a_miss_valid, 1);
    clr_miss = 1;
    cycle();
    clr_miss = 0;
    chk("clr_only_count", a_miss_count, 0);
    chk("clr_only_valid", a_miss_valid, 0);
    chk("clr_addr_holds", a_miss_addr, 32'h4000_0000);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      clr_miss = ($urandom_range(0, 15) == 0);
      s_id     = 8'($urandom);
      s_len    = 4'($urandom);
      case ($urandom_range(0, 4))
        0: s_addr = $urandom_range(0, 32'h0fff_ffff);
        1: s_addr = 32'h1000_0000 + $urandom_range(0, 32'h0fff_ffff);
        2: s_addr = 32'h0000_0f00 + $urandom_range(0, 32'h0000_1200);
        3: s_addr = ($urandom_range(0, 1) != 0) ? 32'h1fff_ffff : 32'h2000_0000;
        default: s_addr = $urandom;
      endcase
      cycle();
    end

    // Reset while the buffer is full drops both beats at once
    clr_miss = 0; m_ready = 0; s_valid = 1;
    s_addr = 32'h0000_0200; cycle();
    s_addr = 32'h1000_0300; cycle();
    ARESET = 1;
    #1;
    chk("midrst_m_valid", a_m_valid, 0);
    chk("midrst_s_ready", a_s_ready, 1);
    chk("midrst_count", a_miss_count, 0);
    model_reset();
    s_valid = 0;
    cycle();
    ARESET = 0; m_ready = 1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_route_slice.md
# addr_route_slice

Registered, parametrised AXI address-channel decode stage for the crossbar, one instance per master AR or AW path. It accepts an address beat over a valid/ready handshake and decodes it against SLAVES inclusive address regions, lowest index winning on overlap. It forwards the beat through a 2-entry skid buffer with the destination index and a decode-error flag attached. Unmapped addresses are routed to a decode-error index (SLAVES) for the default-slave responder and are logged in saturating miss counters.

## Interface
- SLAVES, 2: number of mapped slave regions (1..16).
- ADDR_W, `AXI_ADDR_BITS (32): address width.
- ID_W, 8: transaction ID width.
- LEN_W, 4: burst length width.
- BASE, {'h0000_0000, 'h1000_0000}: per-slave inclusive base address, array [0:SLAVES-1] of ADDR_W.
- LIMIT, {'h0fff_ffff, 'h1fff_ffff}: per-slave inclusive end address, array [0:SLAVES-1] of ADDR_W.
- CNT_W, 16: miss counter width.
- DW, derived: $clog2(SLAVES+1), the width of the destination index.
- ACLK  in  1  clock; all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream ready.
- s_addr / s_id / s_len  in  ADDR_W / ID_W / LEN_W  upstream payload.
- m_valid  out  1  downstream beat valid.
- m_ready  in  1  downstream ready.
- m_addr / m_id / m_len  out  ADDR_W / ID_W / LEN_W  forwarded payload, unmodified.
- m_dest  out  DW  destination slave index; SLAVES means unmapped.
- m_decerr  out  1  1 when m_dest == SLAVES.
- clr_miss  in  1  synchronous clear of the miss log.
- miss_count  out  CNT_W  count of accepted unmapped beats, saturating.
- miss_valid  out  1  sticky flag: at least one miss since the last clear.
- miss_addr  out  ADDR_W  address of the first miss since the last clear.

## Operation
- Decode is combinational on s_addr. hit[i] = (s_addr >= BASE[i]) && (s_addr <= LIMIT[i]).
  - The lowest i with hit[i] set gives dest = i.
  - If no bit is set, dest = SLAVES and decerr = 1.
  - Overlapping regions are legal; lowest index wins.
- A beat is accepted when s_valid && s_ready. The payload, dest and decerr are captured together; the decode is never recomputed downstream.
- Buffer states:
  - EMPTY: m_valid = 0.
  - ONE: main register valid, skid empty.
  - FULL: main and skid both valid.
- s_ready = !skid_valid, driven straight from a register with no combinational path from m_ready.
- Transitions (acc = upstream accept, pop = m_valid && m_ready):
  - EMPTY + acc -> ONE.
  - ONE + acc && !pop -> FULL; the new beat goes to skid.
  - ONE + acc && pop -> ONE; main reloads from input.
  - ONE + pop only -> EMPTY.
  - FULL + pop -> ONE; main reloads from skid. No accept is possible in FULL.
- Ordering is strict FIFO. The m_* outputs hold stable while m_valid && !m_ready.
- Miss log, updated on each accepted beat with decerr:
  - miss_count increments, saturating at 2^CNT_W-1.
  - If miss_valid == 0: miss_valid <= 1 and miss_addr <= s_addr.
- clr_miss:
  - Sets miss_count = 0 and miss_valid = 0; miss_addr holds its value.
  - If clr_miss and a miss accept occur in the same cycle, the accept wins: count = 1, miss_valid = 1, miss_addr = s_addr.

## Timing
- Latency: an accept in cycle N gives m_valid in cycle N+1.
- Throughput: 1 beat/cycle sustained while m_ready = 1.
- With m_ready low, 2 beats are absorbed and s_ready drops the cycle after the second accept.
- s_ready returns high the cycle after the pop that drains skid.
- Miss log outputs update the cycle after the accept or clear.
- Reset values:
  - s_ready = 1, m_valid = 0.
  - m_addr/m_id/m_len = 0, m_dest = 0, m_decerr = 0.
  - miss_count = 0, miss_valid = 0, miss_addr = 0.
- Reset asserted mid-transfer drops buffered beats immediately, with no handshake completion.

## Test plan
- Reset: hold ARESET 3 cycles with s_valid = 1 -> s_ready = 1, m_valid = 0, all outputs 0. Release -> first accept appears one cycle later.
- Mapped streaming: addrs 0x0000_0010, 0x1000_0000, 0x1fff_ffff, 0x0fff_ffff back-to-back with m_ready = 1 -> m_dest 0, 1, 1, 0 on consecutive cycles, m_decerr = 0, IDs in order.
- Unmapped: addr 0x2000_0000, then 0x3000_0004 -> m_dest = 2, m_decerr = 1 both times. miss_count = 2, miss_valid = 1, miss_addr = 0x2000_0000.
- Backpressure: m_ready = 0, offer 3 beats -> 2 accepted, s_ready = 0 from the cycle after the 2nd accept. m_* stable. Raise m_ready -> beats emerge in order, 3rd accepted once skid drains.
- Overlap: SLAVES = 3, region 2 = 0x0000_1000..0x0000_1fff inside region 0, addr 0x0000_1800 -> m_dest = 0.
- Counter edge cases:
  - CNT_W = 2: 5 misses -> miss_count stays 3.
  - clr_miss in the same cycle as a miss accept at 0x4000_0000 -> count = 1, miss_addr = 0x4000_0000.
